// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv: 4-digit multiplexed 7-segment driver for the hh:mm display.
// Once per frame it captures the four digit codes together with the colon and
// leading-zero flags. It then scans digits 3..0, one per slot. Each slot
// starts with a short dark phase and then lights its digit.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   en_i        scan enable; low forces the display dark on the next edge
//   dig3_i..0   4-bit digit codes (hour tens .. minute units)
//   colon_i     colon request, shown on digit 2's decimal point
//   lz_blank_i  blank hour tens when its code is 0
//   an_o        one-hot digit select (registered)
//   seg_o       segments {g,f,e,d,c,b,a} (registered)
//   dp_o        decimal point (registered)
//   frame_o     one-cycle pulse on the cycle the snapshot is taken
module seg7_scan_drv #(
  parameter int unsigned DIG_CYC    = 200,
  parameter int unsigned BLANK_CYC  = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] dig3_i,
  input  logic [3:0] dig2_i,
  input  logic [3:0] dig1_i,
  input  logic [3:0] dig0_i,
  input  logic       colon_i,
  input  logic       lz_blank_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  localparam logic [15:0] DIG_LAST   = 16'(DIG_CYC - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [1:0]  idx_q, idx_n;
  logic        take_snap;

  logic [15:0] snap_q;
  logic        colon_q;
  logic        lz_q;

  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;

  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic        dp_q;
  logic        frame_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // dash marks a corrupt counter code
    endcase
    return s;
  endfunction

  // Next-state logic for the scan FSM and the slot counter.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    take_snap = 1'b0;
    if (!en_i) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      idx_n   = 2'd3;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_n   = ST_BLANK;
          cnt_n     = '0;
          idx_n     = 2'd3;
          take_snap = 1'b1;
        end
        ST_BLANK: begin
          cnt_n = cnt_q + 16'd1;
          if (cnt_q == BLANK_LAST) state_n = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == DIG_LAST) begin
            cnt_n   = '0;
            state_n = ST_BLANK;
            idx_n   = idx_q - 2'd1;  // 0 wraps to 3: start of the next frame
            if (idx_q == 2'd0) take_snap = 1'b1;
          end else begin
            cnt_n = cnt_q + 16'd1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          idx_n   = 2'd3;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so they line up with the state
  // register on the same edge. In SHOW the snapshot is never being replaced,
  // so the registered snapshot is the correct source.
  always_comb begin
    an_n  = '0;
    seg_n = '0;
    dp_n  = 1'b0;
    if (state_n == ST_SHOW &&
        !(idx_n == 2'd3 && lz_q && snap_q[15:12] == 4'd0)) begin
      an_n  = 4'b0001 << idx_n;
      seg_n = seg_decode(snap_q[idx_n*4 +: 4]);
      dp_n  = (idx_n == 2'd2) && colon_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd3;
      snap_q  <= '0;
      colon_q <= 1'b0;
      lz_q    <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      if (take_snap) begin
        snap_q  <= {dig3_i, dig2_i, dig1_i, dig0_i};
        colon_q <= colon_i;
        lz_q    <= lz_blank_i;
      end
      an_q    <= an_n ^ AN_OFF;
      seg_q   <= seg_n ^ SEG_OFF;
      dp_q    <= dp_n ^ DP_OFF;
      frame_q <= take_snap;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

  // Safety checks on the registered anode drive, polarity removed.
  logic [3:0] an_act;
  assign an_act = an_q ^ AN_OFF;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(an_act))
        else $error("an_o not zero/one-hot: %b", an_q);
      assert (!(state_q == ST_BLANK && an_act != 4'h0))
        else $error("an_o active during blank phase: %b", an_q);
    end
  end

endmodule
